// File: rtl/mvu_job_queue.sv
// mvu_job_queue: descriptor FIFO feeding a matrix-vector unit. Jobs are popped
// in order, presented on cfg_desc, started with a one-cycle pulse and then
// supervised until the MVU reports done or a watchdog expires.
module mvu_job_queue #(
    parameter int DEPTH   = 4,
    parameter int BCNTDWN = 29,
    parameter int BPREC   = 6,
    parameter int BBWADDR = 9,
    parameter int BBDADDR = 15,
    parameter int WDOG    = 4096,
    localparam int DW     = BCNTDWN + 3*BPREC + BBWADDR + 2*BBDADDR,
    localparam int LW     = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_desc,
    output logic [DW-1:0] cfg_desc,
    output logic          mvu_start,
    input  logic          mvu_done,
    output logic          busy,
    output logic [LW-1:0] level,
    output logic          irq,
    input  logic          irq_clr,
    output logic          err,
    input  logic          err_clr,
    output logic [15:0]   jobs_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = $clog2(WDOG+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [WW-1:0] r_wdog;
    logic [DW-1:0] r_cfg;
    logic [15:0]   r_jobs;
    logic          r_irq;
    logic          r_err;

    logic          w_push_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_done_ok;
    logic          w_timeout;

    // Ready looks only at the registered level, so a same-cycle pop never frees a slot.
    assign w_push_ready = (r_level < LW'(DEPTH));
    assign w_push       = push_valid & w_push_ready;
    assign w_pop        = (r_state == S_LOAD);
    // A done on the expiry cycle wins over the timeout.
    assign w_done_ok    = (r_state == S_RUN) & mvu_done;
    assign w_timeout    = (r_state == S_RUN) & ~mvu_done & (r_wdog == WW'(WDOG-1));

    assign push_ready = w_push_ready;
    assign level      = r_level;
    assign cfg_desc   = r_cfg;
    assign jobs_done  = r_jobs;
    assign irq        = r_irq;
    assign err        = r_err;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state logic; enable only gates leaving IDLE, never aborts a job.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable && (r_level != '0)) w_next = S_LOAD;
            S_LOAD:  w_next = S_START;
            S_START: w_next = S_RUN;
            S_RUN:   if (w_done_ok || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        mvu_start = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_LOAD:  busy = 1'b1;
            S_START: begin
                busy      = 1'b1;
                mvu_start = 1'b1;
            end
            S_RUN:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Descriptor storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= push_desc;
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Active job descriptor, captured only while popping the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_cfg <= '0;
        else if (w_pop) r_cfg <= r_mem[r_rptr];
    end

    // Watchdog: cleared at start, counts RUN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_wdog <= '0;
        else if (r_state == S_START) r_wdog <= '0;
        else if (r_state == S_RUN)   r_wdog <= r_wdog + WW'(1);
    end

    // Completion counter and sticky flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jobs <= '0;
            r_irq  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_done_ok) begin
                r_jobs <= r_jobs + 16'd1;
                r_irq  <= 1'b1;
            end else if (irq_clr) begin
                r_irq  <= 1'b0;
            end
            if (w_timeout)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvu_job_queue.sv
// Scoreboard bench for mvu_job_queue: stimulus pushes expected descriptors into
// a queue; a negedge monitor pops on every mvu_start and tracks job outcomes.
module tb_mvu_job_queue;

    localparam int DEPTH = 4;
    localparam int WDOG  = 16;
    localparam int DW    = 29 + 3*6 + 9 + 2*15;
    localparam int LW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [DW-1:0] push_desc = '0;
    logic [DW-1:0] cfg_desc;
    logic          mvu_start;
    logic          mvu_done = 1'b0;
    logic          busy;
    logic [LW-1:0] level;
    logic          irq;
    logic          irq_clr = 1'b0;
    logic          err;
    logic          err_clr = 1'b0;
    logic [15:0]   jobs_done;

    always #5 clk = ~clk;

    mvu_job_queue #(.DEPTH(DEPTH), .WDOG(WDOG)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .push_valid(push_valid), .push_ready(push_ready), .push_desc(push_desc),
        .cfg_desc(cfg_desc), .mvu_start(mvu_start), .mvu_done(mvu_done),
        .busy(busy), .level(level), .irq(irq), .irq_clr(irq_clr),
        .err(err), .err_clr(err_clr), .jobs_done(jobs_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state (owned by the monitor).
    logic [DW-1:0] exp_q[$];
    int            m_level = 0;
    bit            m_irq = 0;
    bit            m_err = 0;
    logic [15:0]   m_jobs = '0;
    bit            job_active = 0;
    int            run_idx = 0;
    logic [DW-1:0] last_desc = '0;
    bit            just_finished = 0;
    int            starts_seen = 0;

    // Responder controls.
    int done_delay  = 0;   // cycles after start; 0 = never
    bit random_mode = 0;
    bit stray_done  = 0;

    // MVU responder: done is raised in cycle start+delay, i.e. RUN cycle delay-1.
    initial begin
        int cnt;
        int d;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt > 0) begin
                cnt--;
                mvu_done = (cnt == 0) | stray_done;
            end else begin
                mvu_done = stray_done;
            end
            @(negedge clk);
            if (rst) cnt = 0;
            else if (mvu_start) begin
                d   = random_mode ? int'($urandom_range(1, 20)) : done_delay;
                cnt = d;
            end
        end
    end

    // Monitor: compare DUT against the model, then advance the model to the next edge.
    initial begin
        bit set_irq;
        bit set_err;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_level       = 0;
                m_irq         = 0;
                m_err         = 0;
                m_jobs        = '0;
                job_active    = 0;
                last_desc     = '0;
                just_finished = 0;
            end else begin
                if (mvu_start) begin
                    check("no_overlapping_start", 128'(job_active), 128'(0));
                    check("busy_at_start", 128'(busy), 128'(1));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_start: got mvu_start=1, want no queued job (t=%0t)", $time);
                    end else begin
                        last_desc = exp_q.pop_front();
                        check("cfg_desc_fifo_order", 128'(cfg_desc), 128'(last_desc));
                        m_level--;
                    end
                    job_active = 1;
                    run_idx    = -1;
                    starts_seen++;
                end else begin
                    if (job_active) begin
                        run_idx++;
                        check("busy_in_run", 128'(busy), 128'(1));
                    end
                    check("cfg_desc_hold", 128'(cfg_desc), 128'(last_desc));
                end
                if (just_finished) begin
                    check("idle_after_job", 128'(busy), 128'(0));
                    just_finished = 0;
                end
                check("level", 128'(level), 128'(m_level));
                check("push_ready", 128'(push_ready), 128'(m_level < DEPTH));
                check("jobs_done", 128'(jobs_done), 128'(m_jobs));
                check("irq", 128'(irq), 128'(m_irq));
                check("err", 128'(err), 128'(m_err));

                set_irq = 0;
                set_err = 0;
                if (job_active && run_idx >= 0) begin
                    if (mvu_done) begin
                        set_irq = 1;
                        m_jobs++;
                        job_active    = 0;
                        just_finished = 1;
                    end else if (run_idx == WDOG-1) begin
                        set_err       = 1;
                        job_active    = 0;
                        just_finished = 1;
                    end
                end
                if (set_irq)      m_irq = 1;
                else if (irq_clr) m_irq = 0;
                if (set_err)      m_err = 1;
                else if (err_clr) m_err = 0;
                if (push_valid && m_level < DEPTH) begin
                    exp_q.push_back(push_desc);
                    m_level++;
                end
            end
        end
    end

    function automatic logic [DW-1:0] rand_desc();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        push_valid = 1'b1;
        push_desc  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_drained(input int max, input string name);
        int i;
        for (i = 0; i < max; i++) begin
            if (!busy && level == '0 && exp_q.size() == 0) break;
            tick();
        end
        n_checks++;
        if (i == max) begin
            n_errors++;
            $display("FAIL %s: still busy after %0d cycles, want idle and empty", name, max);
        end
    endtask

    // Stimulus.
    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] ds [5];
        int lat;
        int s0;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("ready_after_reset", 128'(push_ready), 128'(1));
        check("level_after_reset", 128'(level), 128'(0));
        tick();

        // Single job: latency, descriptor, completion.
        enable     = 1'b1;
        done_delay = 10;
        d = rand_desc();
        push_one(d);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mvu_start) begin
                lat = k;
                break;
            end
        end
        check("launch_latency", 128'(lat), 128'(3));
        tick();
        wait_drained(40, "single_job_drain");
        check("single_cfg_desc", 128'(cfg_desc), 128'(d));
        check("single_jobs_done", 128'(jobs_done), 128'(1));
        check("single_irq", 128'(irq), 128'(1));
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        tick();
        check("irq_cleared", 128'(irq), 128'(0));

        // Full FIFO with launching disabled.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) ds[i] = rand_desc();
        push_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_desc = ds[i];
            tick();
        end
        push_valid = 1'b0;
        check("full_level", 128'(level), 128'(4));
        check("full_push_ready", 128'(push_ready), 128'(0));
        tick();
        done_delay = 3;
        enable     = 1'b1;
        wait_drained(100, "full_fifo_drain");
        check("full_jobs_done", 128'(jobs_done), 128'(5));
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;

        // Watchdog: MVU never answers.
        done_delay = 0;
        s0 = starts_seen;
        push_one(rand_desc());
        push_one(rand_desc());
        wait_drained(120, "watchdog_drain");
        check("wdog_err", 128'(err), 128'(1));
        check("wdog_irq", 128'(irq), 128'(0));
        check("wdog_jobs_done", 128'(jobs_done), 128'(5));
        check("wdog_next_job_launched", 128'(starts_seen - s0), 128'(2));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check("err_cleared", 128'(err), 128'(0));

        // Done on the expiry cycle with irq_clr held: completion, set beats clear.
        done_delay = 16;
        irq_clr    = 1'b1;
        push_one(rand_desc());
        wait_drained(60, "expiry_done_drain");
        irq_clr = 1'b0;
        check("expiry_done_jobs", 128'(jobs_done), 128'(6));
        check("expiry_done_no_err", 128'(err), 128'(0));

        // Timeout with err_clr held.
        done_delay = 0;
        err_clr    = 1'b1;
        push_one(rand_desc());
        wait_drained(60, "timeout_clr_drain");
        err_clr = 1'b0;

        // Stray done while idle is ignored.
        stray_done = 1'b1;
        tick();
        tick();
        stray_done = 1'b0;
        tick();
        tick();
        check("stray_done_ignored", 128'(jobs_done), 128'(6));

        // Reset in the middle of a running job with two more queued.
        done_delay = 0;
        push_one(rand_desc());
        push_one(rand_desc());
        push_one(rand_desc());
        repeat (6) tick();
        check("pre_reset_level", 128'(level), 128'(2));
        check("pre_reset_busy", 128'(busy), 128'(1));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_start", 128'(mvu_start), 128'(0));
        check("rst_level", 128'(level), 128'(0));
        check("rst_jobs", 128'(jobs_done), 128'(0));
        check("rst_irq", 128'(irq), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_cfg", 128'(cfg_desc), 128'(0));
        @(posedge clk);
        #3 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_start_after_reset", 128'(mvu_start), 128'(0));
        end
        tick();

        // Randomized traffic.
        random_mode = 1;
        s0 = starts_seen;
        for (int c = 0; c < 800; c++) begin
            enable     = ($urandom_range(0, 9) != 0);
            push_valid = ($urandom_range(0, 2) == 0);
            push_desc  = rand_desc();
            irq_clr    = ($urandom_range(0, 7) == 0);
            err_clr    = ($urandom_range(0, 7) == 0);
            tick();
        end
        push_valid = 1'b0;
        enable     = 1'b1;
        irq_clr    = 1'b0;
        err_clr    = 1'b0;
        wait_drained(500, "random_drain");
        n_checks++;
        if (starts_seen - s0 < 3*DEPTH) begin
            n_errors++;
            $display("FAIL random_job_count: got %0d jobs, want at least %0d", starts_seen - s0, 3*DEPTH);
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL global_timeout: simulation still running, want finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
